// File: rtl/predelay_commutator_if.sv
// Bus between an R2MDC butterfly stage and the pre-delay commutator.
//   master : butterfly side, drives in_valid/bf_out*, observes commutator outputs.
//   slave  : commutator side, consumes bf_out*, drives cm_*, cntr_pairs, busy.
// Signals:
//   in_valid                 bf_out* carry a sample this cycle
//   bf_out0_re/im            path A (undelayed)
//   bf_out1_re/im            path B (delayed inside the commutator)
//   cm_valid                 cm_out* hold a valid pair
//   cm_out0_re/im, cm_out1_*  commutated output pair
//   cntr_pairs               index of the pair currently presented
//   busy                     a frame is in progress
//   proto_err                sticky protocol-violation flag
//                            (only with PRECOMM_PROTOCOL_CHECK_EN defined)
interface predelay_commutator_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 5
) ();
  logic              in_valid;
  logic [DATA_W-1:0] bf_out0_re;
  logic [DATA_W-1:0] bf_out0_im;
  logic [DATA_W-1:0] bf_out1_re;
  logic [DATA_W-1:0] bf_out1_im;
  logic              cm_valid;
  logic [DATA_W-1:0] cm_out0_re;
  logic [DATA_W-1:0] cm_out0_im;
  logic [DATA_W-1:0] cm_out1_re;
  logic [DATA_W-1:0] cm_out1_im;
  logic [CNT_W-1:0]  cntr_pairs;
  logic              busy;
`ifdef PRECOMM_PROTOCOL_CHECK_EN
  logic              proto_err;
`endif

  modport master (
    output in_valid, bf_out0_re, bf_out0_im, bf_out1_re, bf_out1_im,
    input  cm_valid, cm_out0_re, cm_out0_im, cm_out1_re, cm_out1_im, cntr_pairs, busy
`ifdef PRECOMM_PROTOCOL_CHECK_EN
    , input proto_err
`endif
  );

  modport slave (
    input  in_valid, bf_out0_re, bf_out0_im, bf_out1_re, bf_out1_im,
    output cm_valid, cm_out0_re, cm_out0_im, cm_out1_re, cm_out1_im, cntr_pairs, busy
`ifdef PRECOMM_PROTOCOL_CHECK_EN
    , output proto_err
`endif
  );
endinterface

// File: rtl/predelay_commutator.sv
// Pre-delay commutator for an R2MDC pipeline stage.
// Path B is delayed by DELAY samples in a circular buffer; the undelayed path A and the
// delayed path B are then swapped between the two outputs every DELAY output pairs.
// Each frame takes NUM_PAIRS samples per path and emits NUM_PAIRS registered pairs; the
// last DELAY pairs are produced by self-timed drain cycles with zero inputs.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    predelay_commutator_if.slave (input samples, output pairs, cntr_pairs, busy)
// Optional build macro PRECOMM_PROTOCOL_CHECK_EN adds bus.proto_err, a sticky flag set
// the cycle after in_valid is seen while draining.
module predelay_commutator #(
  parameter int unsigned DELAY     = 16,
  parameter int unsigned NUM_PAIRS = 32,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned CNT_W     = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  predelay_commutator_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DELAY);
  // k runs 0 .. NUM_PAIRS+DELAY-1 over a frame (inputs then drain).
  localparam int unsigned KW   = $clog2(NUM_PAIRS + DELAY);
  localparam logic [KW-1:0] KFillEnd  = KW'(DELAY - 1);
  localparam logic [KW-1:0] KRunEnd   = KW'(NUM_PAIRS - 1);
  localparam logic [KW-1:0] KDrainEnd = KW'(NUM_PAIRS + DELAY - 1);

  typedef enum logic [1:0] {StIdle, StFill, StRun, StDrain} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [KW-1:0]       k_q, k_d;
  logic [CNT_W-1:0]    m_q, m_d;
  logic [2*DATA_W-1:0] mem [DELAY];

  logic              cm_valid_q;
  logic [DATA_W-1:0] cm_out0_re_q, cm_out0_im_q, cm_out1_re_q, cm_out1_im_q;
  logic [CNT_W-1:0]  cntr_pairs_q;

  logic                adv;
  logic                emit;
  logic                sel;
  logic [2*DATA_W-1:0] a_word, b_word, b_dly;

  // Drain advances every cycle regardless of in_valid; otherwise in_valid gates everything.
  assign adv    = (state_q == StDrain) || bus.in_valid;
  assign emit   = adv && ((state_q == StRun) || (state_q == StDrain));
  assign a_word = (state_q == StDrain) ? '0 : {bus.bf_out0_re, bus.bf_out0_im};
  assign b_word = (state_q == StDrain) ? '0 : {bus.bf_out1_re, bus.bf_out1_im};
  assign b_dly  = mem[wr_ptr_q];
  // (m / DELAY) mod 2 with DELAY a power of two.
  assign sel    = m_q[PtrW];

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    m_d      = m_q;
    wr_ptr_d = wr_ptr_q;
    if (adv) begin
      k_d      = k_q + 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (emit) begin
      m_d = m_q + 1'b1;
    end
    unique case (state_q)
      StIdle:  if (adv) state_d = StFill;
      StFill:  if (adv && (k_q == KFillEnd)) state_d = StRun;
      StRun:   if (adv && (k_q == KRunEnd)) state_d = StDrain;
      StDrain: begin
        if (k_q == KDrainEnd) begin
          state_d = StIdle;
          k_d     = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      k_q      <= '0;
      m_q      <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      m_q      <= m_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Delay RAM is deliberately not reset; read-before-write at wr_ptr gives B_{k-DELAY}.
  always_ff @(posedge clk) begin
    if (rst_n && adv) begin
      mem[wr_ptr_q] <= b_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cm_valid_q   <= 1'b0;
      cm_out0_re_q <= '0;
      cm_out0_im_q <= '0;
      cm_out1_re_q <= '0;
      cm_out1_im_q <= '0;
      cntr_pairs_q <= '0;
    end else begin
      cm_valid_q <= emit;
      if (emit) begin
        cntr_pairs_q <= m_q;
        if (!sel) begin
          {cm_out0_re_q, cm_out0_im_q} <= a_word;
          {cm_out1_re_q, cm_out1_im_q} <= b_dly;
        end else begin
          {cm_out0_re_q, cm_out0_im_q} <= b_dly;
          {cm_out1_re_q, cm_out1_im_q} <= a_word;
        end
      end else if (state_q == StIdle) begin
        // Index returns to 0 once the frame's last pair has been presented.
        cntr_pairs_q <= '0;
      end
    end
  end

  assign bus.cm_valid   = cm_valid_q;
  assign bus.cm_out0_re = cm_out0_re_q;
  assign bus.cm_out0_im = cm_out0_im_q;
  assign bus.cm_out1_re = cm_out1_re_q;
  assign bus.cm_out1_im = cm_out1_im_q;
  assign bus.cntr_pairs = cntr_pairs_q;
  assign bus.busy       = (state_q != StIdle);

`ifdef PRECOMM_PROTOCOL_CHECK_EN
  logic proto_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      proto_err_q <= 1'b0;
    end else if ((state_q == StDrain) && bus.in_valid) begin
      proto_err_q <= 1'b1;
    end
  end

  assign bus.proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_predelay_commutator.sv
`timescale 1ns/1ps
module tb_predelay_commutator;
  localparam int unsigned D   = 16;
  localparam int unsigned N   = 32;
  localparam int unsigned DW  = 16;
  localparam int unsigned CW  = 5;
  localparam int unsigned D2  = 2;
  localparam int unsigned N2  = 4;
  localparam int unsigned CW2 = 2;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  predelay_commutator_if #(.DATA_W(DW), .CNT_W(CW))  bus  ();
  predelay_commutator_if #(.DATA_W(DW), .CNT_W(CW2)) bus2 ();

  predelay_commutator #(.DELAY(D), .NUM_PAIRS(N), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  predelay_commutator #(.DELAY(D2), .NUM_PAIRS(N2), .DATA_W(DW), .CNT_W(CW2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level) ----------------
  // Accepted samples of the current frame; output m uses A[m+D] (0 past the frame) and B[m].
  logic [DW-1:0] a_re [N];
  logic [DW-1:0] a_im [N];
  logic [DW-1:0] b_re [N];
  logic [DW-1:0] b_im [N];
  int in_cnt      = 0;
  int out_idx     = 0;
  int frames_done = 0;

  task automatic drive(input logic v, input logic [DW-1:0] ar, ai, br, bi);
    bus.in_valid   = v;
    bus.bf_out0_re = ar;
    bus.bf_out0_im = ai;
    bus.bf_out1_re = br;
    bus.bf_out1_im = bi;
    if (v && in_cnt < N) begin
      a_re[in_cnt] = ar;
      a_im[in_cnt] = ai;
      b_re[in_cnt] = br;
      b_im[in_cnt] = bi;
      in_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, 16'hdead, 16'hbeef, 16'hcafe, 16'hf00d);
  endtask

  // Compare process for the main instance.
  logic [63:0]   act_d, exp_d, last_d;
  logic [DW-1:0] ea_re, ea_im;
  bit            hold_ok = 1'b0;
  int            need;
  initial begin
    forever begin
      @(negedge clk);
      act_d = {bus.cm_out0_re, bus.cm_out0_im, bus.cm_out1_re, bus.cm_out1_im};
      if (rst_n !== 1'b1) begin
        hold_ok = 1'b0;
      end else begin
        if (bus.cm_valid === 1'b1) begin
          need = (out_idx + D + 1 < N) ? out_idx + D + 1 : N;
          check("valid_allowed", 96'(in_cnt >= need), 96'(1));
          if (out_idx + D < N) begin
            ea_re = a_re[out_idx + D];
            ea_im = a_im[out_idx + D];
          end else begin
            ea_re = '0;
            ea_im = '0;
          end
          if (((out_idx / D) % 2) == 0)
            exp_d = {ea_re, ea_im, b_re[out_idx], b_im[out_idx]};
          else
            exp_d = {b_re[out_idx], b_im[out_idx], ea_re, ea_im};
          check("pair", {32'(bus.cntr_pairs), act_d}, {32'(out_idx), exp_d});
          out_idx++;
          if (out_idx == N) begin
            out_idx = 0;
            in_cnt  = 0;
            frames_done++;
          end
        end else if (hold_ok) begin
          check("hold_when_invalid", 96'(act_d), 96'(last_d));
        end
        last_d  = act_d;
        hold_ok = 1'b1;
      end
    end
  end

  // Small instance: hand-computed pairs for B=1..4, A=5..8 (im = re+0x10 / re+0x20).
  logic [63:0] exp2 [N2];
  int idx2 = 0;
  initial begin
    exp2[0] = 64'h0007_0017_0001_0021;
    exp2[1] = 64'h0008_0018_0002_0022;
    exp2[2] = 64'h0003_0023_0000_0000;
    exp2[3] = 64'h0004_0024_0000_0000;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus2.cm_valid === 1'b1) begin
        if (idx2 < int'(N2))
          check("dly2_pair",
                {32'(bus2.cntr_pairs), bus2.cm_out0_re, bus2.cm_out0_im,
                 bus2.cm_out1_re, bus2.cm_out1_im},
                {32'(idx2), exp2[idx2]});
        else
          check("dly2_extra_valid", 96'(1), 96'(0));
        idx2++;
      end
    end
  end

  task automatic run_frame(input logic [DW-1:0] ab, bb, input int gap, input bit pin);
    int cyc = 0;
    int k   = 0;
    while (k < int'(N)) begin
      if (gap != 0 && (cyc % gap) == gap - 1) begin
        idle(1);
        if (k > 0) check("busy_in_gap", 96'(bus.busy), 96'(1));
      end else begin
        drive(1'b1, ab + DW'(k), ab + 16'h4000 + DW'(k), bb + DW'(k), bb + 16'h4000 + DW'(k));
        if (pin && k == int'(D) - 1) check("no_valid_before_k16", 96'(bus.cm_valid), 96'(0));
        if (pin && k == int'(D)) begin
          check("first_valid_after_k16", 96'(bus.cm_valid), 96'(1));
          check("first_pair_literal", {32'(bus.cntr_pairs), bus.cm_out0_re, bus.cm_out1_re},
                {32'(0), 16'h0110, 16'h0200});
        end
        if (pin && k == int'(N) - 1)
          check("pair15_literal", {bus.cm_out0_re, bus.cm_out1_re}, {16'h011f, 16'h020f});
        k++;
      end
      cyc++;
    end
  endtask

  task automatic wait_frames(input int target);
    int t = 0;
    while (frames_done < target && t < 400) begin
      idle(1);
      t++;
    end
    check("frame_completed", 96'(frames_done >= target), 96'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.bf_out0_re = '0; bus.bf_out0_im = '0; bus.bf_out1_re = '0; bus.bf_out1_im = '0;
    bus2.in_valid = 1'b0;
    bus2.bf_out0_re = '0; bus2.bf_out0_im = '0; bus2.bf_out1_re = '0; bus2.bf_out1_im = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state.
    check("rst_cm_valid", 96'(bus.cm_valid), 96'(0));
    check("rst_cntr_pairs", 96'(bus.cntr_pairs), 96'(0));
    check("rst_busy", 96'(bus.busy), 96'(0));
    check("rst_data", {bus.cm_out0_re, bus.cm_out0_im, bus.cm_out1_re, bus.cm_out1_im}, 96'(0));
    check("rst_busy_dly2", 96'(bus2.busy), 96'(0));
`ifdef PRECOMM_PROTOCOL_CHECK_EN
    check("rst_proto_err", 96'(bus.proto_err), 96'(0));
`endif

    // DELAY=2, NUM_PAIRS=4 instance.
    for (int i = 0; i < int'(N2); i++) begin
      bus2.in_valid   = 1'b1;
      bus2.bf_out0_re = DW'(5 + i);
      bus2.bf_out0_im = DW'(5 + i + 16'h10);
      bus2.bf_out1_re = DW'(1 + i);
      bus2.bf_out1_im = DW'(1 + i + 16'h20);
      @(posedge clk);
      #1;
    end
    bus2.in_valid = 1'b0;
    idle(6);
    check("dly2_output_count", 96'(idx2), 96'(N2));
    check("dly2_busy_after", 96'(bus2.busy), 96'(0));
    check("dly2_cntr_after", 96'(bus2.cntr_pairs), 96'(0));

    // Reset during RUN with sample k=20 on the bus.
    for (int k = 0; k < 20; k++)
      drive(1'b1, 16'h0b00 + DW'(k), 16'h0b80 + DW'(k), 16'h0c00 + DW'(k), 16'h0c80 + DW'(k));
    check("busy_mid_run", 96'(bus.busy), 96'(1));
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    in_cnt  = 0;
    out_idx = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("post_rst_valid", 96'(bus.cm_valid), 96'(0));
      check("post_rst_cntr", 96'(bus.cntr_pairs), 96'(0));
      check("post_rst_busy", 96'(bus.busy), 96'(0));
    end

    // Continuous frame with the reference pattern.
    run_frame(16'h0100, 16'h0200, 0, 1'b1);
    wait_frames(1);
    check("frame1_busy_after", 96'(bus.busy), 96'(0));
    check("frame1_cntr_wrapped", 96'(bus.cntr_pairs), 96'(0));

    // Same pattern, in_valid low every 3rd cycle.
    run_frame(16'h0100, 16'h0200, 3, 1'b0);
    wait_frames(2);
    check("gapped_busy_after", 96'(bus.busy), 96'(0));

    // Two frames separated by one idle cycle.
    run_frame(16'h0500, 16'h0600, 0, 1'b0);
    wait_frames(3);
    run_frame(16'h0700, 16'h0800, 0, 1'b0);
    wait_frames(4);

    // in_valid during the third drain cycle must be dropped.
    run_frame(16'h0900, 16'h0a00, 0, 1'b0);
    idle(2);
`ifdef PRECOMM_PROTOCOL_CHECK_EN
    check("proto_err_before", 96'(bus.proto_err), 96'(0));
`endif
    drive(1'b1, 16'hffff, 16'hffff, 16'heeee, 16'heeee);
`ifdef PRECOMM_PROTOCOL_CHECK_EN
    check("proto_err_set", 96'(bus.proto_err), 96'(1));
`endif
    wait_frames(5);
    check("final_busy", 96'(bus.busy), 96'(0));
    idle(3);
    check("final_no_valid", 96'(bus.cm_valid), 96'(0));
`ifdef PRECOMM_PROTOCOL_CHECK_EN
    check("proto_err_sticky", 96'(bus.proto_err), 96'(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/predelay_commutator.md
Name: predelay_commutator

Overview:
- Feeds the post-delay commutator: sits between one R2MDC butterfly output and the next stage's commutator/post-delay block.
- Delays butterfly path 1 by DELAY samples, then swaps the two paths every DELAY samples.
- Emits aligned pairs plus a per-frame pair counter that drives the downstream post-delay block's save index.

Parameters:
- DELAY, 16, pre-commutator delay depth in samples; also the commutator switching period. Power of 2, ≥2.
- NUM_PAIRS, 32, pairs per path per frame. Multiple of 2*DELAY.
- DATA_W, 16, width of each re/im word.
- CNT_W, 5, pair counter width; equals log2(NUM_PAIRS).

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST_N  in  1  synchronous active-low reset.
- in_valid  in  1  bf_out* carry a sample this cycle.
- bf_out0_re / bf_out0_im  in  DATA_W each  butterfly path 0 (A), undelayed.
- bf_out1_re / bf_out1_im  in  DATA_W each  butterfly path 1 (B), delayed internally.
- cm_valid  out  1  cm_out* hold a valid pair.
- cm_out0_re / cm_out0_im  out  DATA_W each  commutator output 0.
- cm_out1_re / cm_out1_im  out  DATA_W each  commutator output 1.
- cntr_pairs  out  CNT_W  index m of the current output pair, 0..NUM_PAIRS-1.
- busy  out  1  high in FILL, RUN or DRAIN.

Behaviour:
- Reset (RST_N=0 at clock edge): FSM→IDLE; write pointer, sample counter k and output counter m cleared; all outputs 0. Delay RAM contents are not cleared. Reset mid-frame aborts the frame; no partial outputs follow.
- Delay line: circular buffer of DELAY entries, 2*DATA_W wide. Each advance reads B_{k-DELAY} at wr_ptr, then writes B_k. wr_ptr wraps DELAY-1→0.
- Advance condition:
  - in_valid=1 in IDLE/FILL/RUN.
  - Every cycle in DRAIN, with A and B treated as 0.
- FSM:
  - IDLE: in_valid → FILL, k=1 (sample 0 stored).
  - FILL (k<DELAY): advances store only; cm_valid=0. When k reaches DELAY → RUN.
  - RUN: each advance produces an output. On the advance with k=NUM_PAIRS-1 → DRAIN.
  - DRAIN: DELAY self-timed cycles; in_valid ignored. After the last drain output → IDLE.
  - Back-to-back frames are not overlapped: in_valid in DRAIN is a protocol violation and its data is dropped.
- Commutator, output m=k-DELAY, sel=(m/DELAY) mod 2:
  - sel=0: cm_out0=A_k, cm_out1=B_{k-DELAY}.
  - sel=1: cm_out0=B_{k-DELAY}, cm_out1=A_k.
- Output timing:
  - Outputs registered: the pair for advance k appears one cycle later with cm_valid=1 and cntr_pairs=m.
  - Latency from input B_j to its output is DELAY advances + 1 cycle.
  - Exactly NUM_PAIRS valid outputs per frame, m=0..NUM_PAIRS-1, cntr_pairs wrapping to 0 at frame end.
  - cm_valid=0 holds the last data values; it does not force X.
- Gaps: in_valid=0 in FILL/RUN stalls everything. Pointers and counters hold; cm_valid=0 next cycle.
- Arithmetic: no data arithmetic; pure routing. Counters are unsigned and wrap modulo their width.
- busy=1 from the first accepted sample until the cycle the FSM returns to IDLE.

Optional Feature:
- Macro: PRECOMM_PROTOCOL_CHECK_EN.
- With macro: adds output port proto_err (1 bit), sticky, cleared only by reset. Set the cycle after in_valid=1 is seen in DRAIN.
- Without macro: no proto_err port; violations are silently dropped.

Test Plan:
- Reset during RUN (k=20), then idle 5 cycles → cm_valid stays 0, cntr_pairs=0, busy=0; next frame starts cleanly at m=0.
- DELAY=16, NUM_PAIRS=32, continuous in_valid, A_k=16'h0100+k, B_k=16'h0200+k:
  - cm_valid first high the cycle after input k=16.
  - m=0..15: cm_out0_re=0x0110+m, cm_out1_re=0x0200+m.
  - m=16..31: cm_out0_re=0x0200+m, cm_out1_re=0 (drain).
  - 32 valid outputs total, then busy=0.
- Same frame with in_valid deasserted every 3rd cycle → identical output data sequence, cm_valid gapped correspondingly, cntr_pairs strictly increments per valid.
- cntr_pairs wrap: two frames separated by 1 idle cycle → second frame outputs restart at cntr_pairs=0 with correct A/B routing.
- With PRECOMM_PROTOCOL_CHECK_EN: in_valid=1 during DRAIN cycle 3 → proto_err=1 next cycle and stays set; drain outputs unchanged (A=0).
- DELAY=2, NUM_PAIRS=4: B=1,2,3,4 and A=5,6,7,8 → (cm_out0,cm_out1) pairs = (7,1),(8,2),(3,0),(4,0).
